// File: rtl/parking_gate_arbiter.sv
// rtl/parking_gate_arbiter.sv - round-robin gate arbiter with password check, lockout and slot tracking
module parking_gate_arbiter #(
  parameter int N         = 8,
  parameter int NUM_GATES = 2,
  parameter int MAX_TRIES = 3,
  parameter int TIMEOUT   = 16,
  localparam int W        = $clog2(N) + 1,
  localparam int GW       = $clog2(NUM_GATES) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_GATES-1:0]   req,
  input  logic [NUM_GATES*W-1:0] req_flat,
  input  logic [NUM_GATES*W-1:0] req_pwd,
  output logic                   db_rd_en,
  output logic [W-1:0]           db_addr,
  input  logic [W-1:0]           db_rd_data,
  input  logic                   db_rd_valid,
  input  logic                   exit_valid,
  input  logic [W-1:0]           exit_flat,
  output logic                   exit_ready,
  input  logic                   unlock,
  input  logic [W-1:0]           unlock_flat,
  output logic                   resp_valid,
  output logic [GW-1:0]          resp_gate,
  output logic [2:0]             resp_code,
  output logic [NUM_GATES-1:0]   gate_open,
  output logic [N:0]             occupied
);

  localparam int FW = $clog2(MAX_TRIES + 1);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [FW-1:0] MAX_F = FW'(MAX_TRIES);

  localparam logic [2:0] C_GRANT    = 3'd0;
  localparam logic [2:0] C_BAD_FLAT = 3'd1;
  localparam logic [2:0] C_WRONG    = 3'd2;
  localparam logic [2:0] C_LOCKED   = 3'd3;
  localparam logic [2:0] C_ALREADY  = 3'd4;
  localparam logic [2:0] C_TIMEOUT  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WAIT, S_RESP} state_t;

  state_t         state, state_n;
  logic [GW-1:0]  rr, gate_q;
  logic [W-1:0]   flat_q, pwd_q, flat_idx;
  logic [2:0]     code_q, code_n;
  logic [TW-1:0]  timer;
  logic [FW-1:0]  fails [0:N];

  logic           found, win_flat_ok, exit_ok, unlock_ok;
  logic [W-1:0]   win_flat, win_pwd, win_idx;
  logic [NUM_GATES-1:0] req_rot;
  int             sel;

  function automatic logic flat_valid(input logic [W-1:0] f);
    return (f != '0) && (int'(f) <= N + 1);
  endfunction

  // Round-robin: first asserted request at or after rr, wrapping.
  always_comb begin
    found   = 1'b0;
    sel     = 0;
    req_rot = '0;
    for (int i = 0; i < NUM_GATES; i++) begin
      req_rot = req >> ((int'(rr) + i) % NUM_GATES);
      if (!found && req_rot[0]) begin
        found = 1'b1;
        sel   = (int'(rr) + i) % NUM_GATES;
      end
    end
    win_flat    = W'(req_flat >> (sel * W));
    win_pwd     = W'(req_pwd >> (sel * W));
    win_flat_ok = flat_valid(win_flat);
    win_idx     = win_flat_ok ? win_flat - 1'b1 : '0;
  end

  assign flat_idx  = flat_q - 1'b1;
  assign exit_ok   = flat_valid(exit_flat);
  assign unlock_ok = flat_valid(unlock_flat);

  always_comb begin
    state_n = state;
    code_n  = code_q;
    case (state)
      S_IDLE: begin
        if (found) begin
          if (!win_flat_ok) begin
            code_n  = C_BAD_FLAT;
            state_n = S_RESP;
          end else if (fails[win_idx] == MAX_F) begin
            code_n  = C_LOCKED;
            state_n = S_RESP;
          end else if (occupied[win_idx]) begin
            code_n  = C_ALREADY;
            state_n = S_RESP;
          end else begin
            state_n = S_LOOKUP;
          end
        end
      end
      S_LOOKUP: state_n = S_WAIT;
      S_WAIT: begin
        if (db_rd_valid) begin
          code_n  = (db_rd_data == pwd_q) ? C_GRANT : C_WRONG;
          state_n = S_RESP;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          code_n  = C_TIMEOUT;
          state_n = S_RESP;
        end
      end
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      rr       <= '0;
      gate_q   <= '0;
      flat_q   <= '0;
      pwd_q    <= '0;
      code_q   <= '0;
      timer    <= '0;
      occupied <= '0;
      for (int f = 0; f <= N; f++) fails[f] <= '0;
    end else begin
      state  <= state_n;
      code_q <= code_n;
      if (state == S_IDLE && found) begin
        gate_q <= GW'(sel);
        flat_q <= win_flat;
        pwd_q  <= win_pwd;
        rr     <= GW'((sel + 1) % NUM_GATES);
      end
      if (state == S_LOOKUP)    timer <= '0;
      else if (state == S_WAIT) timer <= timer + 1'b1;
      if (state == S_WAIT && db_rd_valid) begin
        if (db_rd_data == pwd_q) begin
          occupied[flat_idx] <= 1'b1;
          fails[flat_idx]    <= '0;
        end else if (fails[flat_idx] != MAX_F) begin
          fails[flat_idx] <= fails[flat_idx] + 1'b1;
        end
      end
      if (exit_valid && exit_ready && exit_ok) occupied[exit_flat - 1'b1] <= 1'b0;
      // Placed last so an admin unlock overrides a same-cycle failure increment.
      if (unlock && unlock_ok) fails[unlock_flat - 1'b1] <= '0;
    end
  end

  assign db_rd_en   = (state == S_LOOKUP);
  assign db_addr    = db_rd_en ? flat_idx : '0;
  assign resp_valid = (state == S_RESP);
  assign resp_gate  = resp_valid ? gate_q : '0;
  assign resp_code  = resp_valid ? code_q : '0;
  assign gate_open  = (resp_valid && code_q == C_GRANT) ? (NUM_GATES'(1) << gate_q) : '0;
  assign exit_ready = !rst && (state != S_WAIT);

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// tb/tb_parking_gate_arbiter.sv - scoreboard bench for parking_gate_arbiter
module tb_parking_gate_arbiter;
  localparam int N = 8, G = 2, W = 4, GW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [G-1:0]   req;
  logic [G*W-1:0] req_flat, req_pwd;
  logic           db_rd_en;
  logic [W-1:0]   db_addr, db_rd_data;
  logic           db_rd_valid;
  logic           exit_valid, exit_ready, unlock, resp_valid;
  logic [W-1:0]   exit_flat, unlock_flat;
  logic [GW-1:0]  resp_gate;
  logic [2:0]     resp_code;
  logic [G-1:0]   gate_open;
  logic [N:0]     occupied;

  parking_gate_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_flat(req_flat), .req_pwd(req_pwd),
    .db_rd_en(db_rd_en), .db_addr(db_addr), .db_rd_data(db_rd_data), .db_rd_valid(db_rd_valid),
    .exit_valid(exit_valid), .exit_flat(exit_flat), .exit_ready(exit_ready),
    .unlock(unlock), .unlock_flat(unlock_flat), .resp_valid(resp_valid),
    .resp_gate(resp_gate), .resp_code(resp_code), .gate_open(gate_open), .occupied(occupied)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int exp_q[$];
  int en_cnt = 0, last_addr = -1;
  bit pend = 1'b0, withhold = 1'b0;
  int pend_addr = 0;
  logic [W-1:0] dbmem [0:N];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Password DB model: data returned one cycle after the read strobe.
  always @(negedge clk) begin
    db_rd_valid = 1'b0;
    if (pend && !withhold) begin
      db_rd_valid = 1'b1;
      db_rd_data  = dbmem[pend_addr];
    end
    pend = 1'b0;
    if (db_rd_en) begin
      pend      = 1'b1;
      pend_addr = int'(db_addr);
      last_addr = int'(db_addr);
      en_cnt++;
    end
  end

  // Scoreboard monitor: each verdict pops one expectation encoded as gate*8+code.
  int e_item, e_gate, e_code, e_open;
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_resp gate=%0d code=%0d", resp_gate, resp_code);
      end else begin
        e_item = exp_q.pop_front();
        e_gate = e_item / 8;
        e_code = e_item % 8;
        e_open = (e_code == 0) ? (1 << e_gate) : 0;
        if ({resp_gate, resp_code, gate_open} !== {GW'(e_gate), 3'(e_code), G'(e_open)}) begin
          failures++;
          $display("FAIL resp actual gate=%0d code=%0d open=%b expected gate=%0d code=%0d open=%b",
                   resp_gate, resp_code, gate_open, e_gate, e_code, G'(e_open));
        end
      end
    end
  end

  task automatic do_req(input string name, input int g, input int flat, input int pwd,
                        input int code, input int lat, input int n_en);
    int n, start_en;
    bit got;
    @(negedge clk);
    req_flat[g*W +: W] = W'(flat);
    req_pwd[g*W +: W]  = W'(pwd);
    req[g]             = 1'b1;
    exp_q.push_back(g * 8 + code);
    start_en = en_cnt;
    n   = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      if (resp_valid === 1'b1) got = 1'b1;
    end
    req[g] = 1'b0;
    chk({name, "_latency"}, got ? n : -1, lat);
    chk({name, "_db_reads"}, en_cnt - start_en, n_en);
  endtask

  task automatic do_exit(input string name, input int flat, input int ready, input int occ_after);
    @(negedge clk);
    exit_valid = 1'b1;
    exit_flat  = W'(flat);
    chk({name, "_ready"}, int'(exit_ready), ready);
    @(negedge clk);
    exit_valid = 1'b0;
    chk({name, "_occ"}, int'(occupied), occ_after);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, n, start_en;
    for (int i = 0; i <= N; i++) dbmem[i] = W'(i + 3);
    rst = 1'b1; req = '0; req_flat = '0; req_pwd = '0;
    exit_valid = 1'b0; exit_flat = '0; unlock = 1'b0; unlock_flat = '0;
    db_rd_valid = 1'b0; db_rd_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_db_rd_en", int'(db_rd_en), 0);
    chk("rst_occupied", int'(occupied), 0);
    chk("rst_gate_open", int'(gate_open), 0);
    chk("rst_exit_ready", int'(exit_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_exit_ready", int'(exit_ready), 1);

    // Grant path and precheck boundaries
    do_req("grant_f3", 0, 3, 5, 0, 3, 1);
    chk("grant_db_addr", last_addr, 2);
    chk("grant_occ", int'(occupied), 9'h004);
    do_req("already_f3", 0, 3, 5, 4, 1, 0);
    do_req("bad_f0", 1, 0, 0, 1, 1, 0);
    do_req("bad_f10", 0, 10, 0, 1, 1, 0);
    do_req("grant_f9", 0, 9, 11, 0, 3, 1);
    chk("grant_f9_occ", int'(occupied), 9'h104);
    do_exit("exit_f0", 0, 1, 9'h104);
    do_exit("exit_f9", 9, 1, 9'h004);
    do_exit("exit_f3", 3, 1, 9'h000);

    // Lockout, then admin unlock
    do_req("wrong1", 0, 3, 4, 2, 3, 1);
    do_req("wrong2", 0, 3, 4, 2, 3, 1);
    do_req("wrong3", 0, 3, 4, 2, 3, 1);
    do_req("locked", 0, 3, 5, 3, 1, 0);
    @(negedge clk); unlock = 1'b1; unlock_flat = 4'd3;
    @(negedge clk); unlock = 1'b0;
    do_req("unlocked_grant", 0, 3, 5, 0, 3, 1);

    // Unlock concurrent with a wrong-password update must leave the counter cleared
    do_req("f4_wrong1", 1, 4, 1, 2, 3, 1);
    do_req("f4_wrong2", 1, 4, 1, 2, 3, 1);
    unlock = 1'b1; unlock_flat = 4'd4;
    do_req("f4_wrong_unlock", 1, 4, 1, 2, 3, 1);
    unlock = 1'b0;
    do_req("f4_wrong4", 1, 4, 1, 2, 3, 1);
    do_req("f4_wrong5", 1, 4, 1, 2, 3, 1);
    do_req("f4_grant", 1, 4, 6, 0, 3, 1);
    chk("occ_f3_f4", int'(occupied), 9'h00C);

    // DB timeout; exit stalled while waiting
    withhold = 1'b1;
    fork
      do_req("timeout", 1, 5, 7, 5, 18, 1);
      begin
        repeat (5) @(negedge clk);
        exit_valid = 1'b1;
        exit_flat  = 4'd3;
        chk("wait_exit_ready", int'(exit_ready), 0);
        @(negedge clk);
        exit_valid = 1'b0;
      end
    join
    chk("timeout_occ", int'(occupied), 9'h00C);

    // Reset while waiting on the DB: no verdict, state cleared
    @(negedge clk);
    req_flat[W +: W] = 4'd6;
    req_pwd[W +: W]  = 4'd8;
    req[1]           = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    chk("midrst_occ", int'(occupied), 0);
    chk("midrst_resp", int'(resp_valid), 0);
    rst = 1'b0;
    withhold = 1'b0;
    repeat (20) @(negedge clk);

    // Both gates requesting continuously alternate, starting at gate0 after reset
    @(negedge clk);
    req_flat = {4'd10, 4'd0};
    req      = 2'b11;
    exp_q.push_back(0 * 8 + 1);
    exp_q.push_back(1 * 8 + 1);
    exp_q.push_back(0 * 8 + 1);
    exp_q.push_back(1 * 8 + 1);
    start_en = en_cnt;
    cnt = 0;
    n   = 0;
    while (cnt < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (resp_valid === 1'b1) cnt++;
    end
    req = '0;
    chk("rr_count", cnt, 4);
    chk("rr_cycles", n, 7);
    chk("rr_db_reads", en_cnt - start_en, 0);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
